tb_core_data_router: RTL and testbench

// - Routes the cv32e40p data port to NT TCDM-style targets (periph, stack, dmem) by address window.
// - Serves the MMIO window locally: EXIT and PRINT registers. Unmapped addresses get an error response.
// - Keeps an in-order outstanding-ID FIFO, so r_data/r_valid return to the core in request order.
// - Sits between i_cv32e40p_core and the dummy memories / redmule_wrap periph port in the Verilator bench.

---
 rtl/tb_router_pkg.sv | 30 +++
 rtl/tb_router_id_fifo.sv | 57 +++++
 rtl/tb_core_data_router.sv | 150 +++++++++++++++
 tb/tb_tb_core_data_router.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_router_pkg.sv
// Shared types and constants for the core data router: target ids, address windows
// and the fixed MMIO register layout.
package tb_router_pkg;

  localparam int ROUTER_NT = 3;
  localparam int ID_W = $clog2(ROUTER_NT + 2);

  typedef logic [ID_W-1:0] tgt_id_t;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] size;
  } region_t;

  localparam tgt_id_t ID_LOCAL = tgt_id_t'(ROUTER_NT);
  localparam tgt_id_t ID_ERR = tgt_id_t'(ROUTER_NT + 1);

  localparam logic [31:0] MMIO_EXIT_OFS = 32'h0;
  localparam logic [31:0] MMIO_PRINT_OFS = 32'h4;
  localparam logic [31:0] MMIO_SIZE = 32'h10;
  localparam logic [31:0] ERR_RDATA = 32'hBADA_CCE5;

  // The limit is computed on 33 bits so a window ending at 4 GiB cannot wrap to zero.
  function automatic logic in_region(region_t r, logic [31:0] addr);
    logic [32:0] lim;
    lim = {1'b0, r.base} + {1'b0, r.size};
    return (addr >= r.base) && ({1'b0, addr} < lim);
  endfunction

endpackage

// File: rtl/tb_router_id_fifo.sv
// In-order FIFO of outstanding request ids; the head decides which source answers the core.
module tb_router_id_fifo
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             head_age_nonzero
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage is registered with no write-through, so any visible head was pushed
  // in an earlier cycle.
  assign head_age_nonzero = ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tb_core_data_router.sv
// Routes the core data port to NT memory targets by address window, serves the EXIT/PRINT
// MMIO registers locally and returns responses in request order. NT must equal ROUTER_NT.
module tb_core_data_router
  import tb_router_pkg::*;
#(
  parameter int          NT              = ROUTER_NT,
  parameter int          MAX_OUTST       = 4,
  parameter logic [31:0] BASE_ADDR [NT]  = '{32'h0000_1000, 32'h0014_0000, 32'h0011_0000},
  parameter logic [31:0] WIN_SIZE  [NT]  = '{32'h000F_F000, 32'h0003_0000, 32'h0003_0000},
  parameter logic [31:0] MMIO_ADDR       = 32'h8000_0000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             data_req_i,
  output logic             data_gnt_o,
  input  logic             data_we_i,
  input  logic [3:0]       data_be_i,
  input  logic [31:0]      data_addr_i,
  input  logic [31:0]      data_wdata_i,
  output logic             data_rvalid_o,
  output logic [31:0]      data_rdata_o,
  output logic             data_err_o,
  output logic [NT-1:0]    tgt_req_o,
  input  logic [NT-1:0]    tgt_gnt_i,
  output logic [NT*32-1:0] tgt_add_o,
  output logic [NT-1:0]    tgt_wen_o,
  output logic [NT*4-1:0]  tgt_be_o,
  output logic [NT*32-1:0] tgt_data_o,
  input  logic [NT*32-1:0] tgt_r_data_i,
  input  logic [NT-1:0]    tgt_r_valid_i,
  output logic             exit_valid_o,
  output logic [31:0]      exit_code_o,
  output logic             print_valid_o,
  output logic [7:0]       print_char_o
);

  tgt_id_t     req_id;
  tgt_id_t     head;
  logic        sel_gnt;
  logic        accept_ok;
  logic        full;
  logic        empty;
  logic        head_aged;
  logic        head_rv;
  logic [31:0] head_rd;
  logic        head_is_local;
  logic        stray_rvalid;
  logic        viol_q;
  logic        local_wr;
  logic [31:0] local_ofs;
  logic        hit_exit;
  logic        hit_print;

  // Unmatched addresses fall through to ID_ERR; the MMIO window overrides target windows.
  always_comb begin
    req_id = ID_ERR;
    for (int i = 0; i < NT; i++) begin
      if (in_region(region_t'{base: BASE_ADDR[i], size: WIN_SIZE[i]}, data_addr_i))
        req_id = tgt_id_t'(i);
    end
    if (in_region(region_t'{base: MMIO_ADDR, size: MMIO_SIZE}, data_addr_i))
      req_id = ID_LOCAL;
  end

  always_comb begin
    sel_gnt = 1'b1;
    for (int i = 0; i < NT; i++) begin
      if (req_id == tgt_id_t'(i)) sel_gnt = tgt_gnt_i[i];
    end
  end

  // Handshake: the core holds data_req_i until data_gnt_o; a request is accepted in the
  // cycle both are high. Targets see req/gnt the same way, and each accepted request is
  // answered by exactly one data_rvalid_o, in acceptance order.
  assign accept_ok  = data_req_i & ~full;
  assign data_gnt_o = accept_ok & sel_gnt;

  for (genvar g = 0; g < NT; g++) begin : g_tgt
    assign tgt_req_o[g] = accept_ok & (req_id == tgt_id_t'(g));
  end

  assign tgt_add_o  = {NT{data_addr_i}};
  assign tgt_wen_o  = {NT{~data_we_i}};
  assign tgt_be_o   = {NT{data_be_i}};
  assign tgt_data_o = {NT{data_wdata_i}};

  tb_router_id_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk              (clk_i),
    .rst_n            (rst_ni),
    .push             (data_gnt_o),
    .push_data        (req_id),
    .pop              (data_rvalid_o),
    .head             (head),
    .full             (full),
    .empty            (empty),
    .head_age_nonzero (head_aged)
  );

  always_comb begin
    head_rv      = 1'b0;
    head_rd      = '0;
    stray_rvalid = 1'b0;
    for (int i = 0; i < NT; i++) begin
      if (head == tgt_id_t'(i)) begin
        head_rv = tgt_r_valid_i[i];
        head_rd = tgt_r_data_i[i*32 +: 32];
      end else if (tgt_r_valid_i[i]) begin
        stray_rvalid = 1'b1;
      end
    end
    // With nothing outstanding, a late r_valid has no owner and is simply dropped.
    stray_rvalid = stray_rvalid & ~empty;
  end

  assign head_is_local = (head == ID_LOCAL) || (head == ID_ERR);
  assign data_rvalid_o = ~empty & (head_is_local ? head_aged : head_rv);
  assign data_rdata_o  = !data_rvalid_o     ? 32'h0 :
                         (head == ID_ERR)   ? ERR_RDATA :
                         head_is_local      ? 32'h0 : head_rd;
  assign data_err_o    = data_rvalid_o & ((head == ID_ERR) | viol_q);

  assign local_wr  = data_gnt_o & data_we_i & (req_id == ID_LOCAL);
  assign local_ofs = data_addr_i - MMIO_ADDR;
  assign hit_exit  = local_wr & (local_ofs == MMIO_EXIT_OFS);
  assign hit_print = local_wr & (local_ofs == MMIO_PRINT_OFS);

  // viol_q marks the next core response as errored after an out-of-order target reply.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exit_valid_o  <= 1'b0;
      exit_code_o   <= 32'hFFFF_FFFF;
      print_valid_o <= 1'b0;
      print_char_o  <= '0;
      viol_q        <= 1'b0;
    end else begin
      exit_valid_o  <= hit_exit;
      print_valid_o <= hit_print;
      if (hit_exit) exit_code_o <= data_wdata_i;
      if (hit_print) print_char_o <= data_wdata_i[7:0];
      viol_q <= stray_rvalid | (viol_q & ~data_rvalid_o);
    end
  end

  a_rvalid_from_head: assert property (@(posedge clk_i) disable iff (!rst_ni) !stray_rvalid)
    else $warning("target r_valid received from a target that is not at the FIFO head");

endmodule

// File: tb/tb_tb_core_data_router.sv
// Directed and randomized bench for tb_core_data_router against a queue-based model of
// outstanding requests.
module tb_tb_core_data_router;

  localparam int NT = 3;
  localparam int MAX_OUTST = 4;
  localparam logic [31:0] BAD = 32'hBADA_CCE5;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             data_req_i;
  logic             data_gnt_o;
  logic             data_we_i;
  logic [3:0]       data_be_i;
  logic [31:0]      data_addr_i;
  logic [31:0]      data_wdata_i;
  logic             data_rvalid_o;
  logic [31:0]      data_rdata_o;
  logic             data_err_o;
  logic [NT-1:0]    tgt_req_o;
  logic [NT-1:0]    tgt_gnt_i;
  logic [NT*32-1:0] tgt_add_o;
  logic [NT-1:0]    tgt_wen_o;
  logic [NT*4-1:0]  tgt_be_o;
  logic [NT*32-1:0] tgt_data_o;
  logic [NT*32-1:0] tgt_r_data_i;
  logic [NT-1:0]    tgt_r_valid_i;
  logic             exit_valid_o;
  logic [31:0]      exit_code_o;
  logic             print_valid_o;
  logic [7:0]       print_char_o;

  always #5 clk_i = ~clk_i;

  tb_core_data_router dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .data_req_i    (data_req_i),
    .data_gnt_o    (data_gnt_o),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_addr_i   (data_addr_i),
    .data_wdata_i  (data_wdata_i),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o),
    .data_err_o    (data_err_o),
    .tgt_req_o     (tgt_req_o),
    .tgt_gnt_i     (tgt_gnt_i),
    .tgt_add_o     (tgt_add_o),
    .tgt_wen_o     (tgt_wen_o),
    .tgt_be_o      (tgt_be_o),
    .tgt_data_o    (tgt_data_o),
    .tgt_r_data_i  (tgt_r_data_i),
    .tgt_r_valid_i (tgt_r_valid_i),
    .exit_valid_o  (exit_valid_o),
    .exit_code_o   (exit_code_o),
    .print_valid_o (print_valid_o),
    .print_char_o  (print_char_o)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Kind of each outstanding request: 0..2 target index, 3 local MMIO, 4 unmapped.
  logic [2:0]  exp_q[$];
  logic        viol_pend;
  logic        m_exit_valid;
  logic        m_print_valid;
  logic [31:0] m_exit_code;
  logic [7:0]  m_print_char;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] decode(input logic [31:0] a);
    if (a >= 32'h0000_1000 && a < 32'h0010_0000) return 3'd0;
    if (a >= 32'h0014_0000 && a < 32'h0017_0000) return 3'd1;
    if (a >= 32'h0011_0000 && a < 32'h0014_0000) return 3'd2;
    if (a >= 32'h8000_0000 && a < 32'h8000_0010) return 3'd3;
    return 3'd4;
  endfunction

  function automatic logic [2:0] head_rv_onehot();
    if (exp_q.size() != 0 && exp_q[0] < 3'd3) return 3'b001 << exp_q[0];
    return 3'b000;
  endfunction

  // One clock cycle: drive after the edge, compare mid-cycle, advance the model at the edge.
  task automatic step(input logic req, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] gnt, input logic [2:0] rv);
    logic [31:0] rd [3];
    logic [2:0]  kind;
    logic [2:0]  h;
    logic [2:0]  exp_treq;
    logic [31:0] exp_rdata;
    logic [31:0] ofs;
    logic [3:0]  be;
    logic        exp_gnt, exp_rv, exp_err, stray;
    for (int i = 0; i < 3; i++) rd[i] = $urandom;
    be            = 4'($urandom_range(0, 15));
    data_req_i    = req;
    data_we_i     = we;
    data_be_i     = be;
    data_addr_i   = addr;
    data_wdata_i  = wdata;
    tgt_gnt_i     = gnt;
    tgt_r_valid_i = rv;
    tgt_r_data_i  = {rd[2], rd[1], rd[0]};
    @(negedge clk_i);
    kind     = decode(addr);
    exp_gnt  = req && (exp_q.size() < MAX_OUTST) && ((kind >= 3'd3) ? 1'b1 : gnt[kind]);
    exp_treq = (req && exp_q.size() < MAX_OUTST && kind < 3'd3) ? (3'b001 << kind) : 3'b000;
    exp_rv = 1'b0; exp_rdata = 32'h0; exp_err = 1'b0; stray = 1'b0;
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      if (h < 3'd3) begin
        exp_rv = rv[h]; exp_rdata = rd[h]; exp_err = viol_pend;
      end else begin
        exp_rv = 1'b1; exp_rdata = (h == 3'd4) ? BAD : 32'h0; exp_err = (h == 3'd4) || viol_pend;
      end
      for (int i = 0; i < 3; i++) if (rv[i] && h != 3'(i)) stray = 1'b1;
    end
    check("gnt", data_gnt_o, exp_gnt);
    check("tgt_req", tgt_req_o, exp_treq);
    check("rvalid", data_rvalid_o, exp_rv);
    if (exp_rv) begin
      check("rdata", data_rdata_o, exp_rdata);
      check("err", data_err_o, exp_err);
    end
    check("tgt_add", tgt_add_o, {addr, addr, addr});
    check("tgt_wen", tgt_wen_o, {3{~we}});
    check("tgt_be", tgt_be_o, {be, be, be});
    check("tgt_data", tgt_data_o, {wdata, wdata, wdata});
    check("exit_valid", exit_valid_o, m_exit_valid);
    check("print_valid", print_valid_o, m_print_valid);
    check("exit_code", exit_code_o, m_exit_code);
    check("print_char", print_char_o, m_print_char);
    @(posedge clk_i);
    if (exp_rv) void'(exp_q.pop_front());
    if (exp_gnt) exp_q.push_back(kind);
    viol_pend = stray || (viol_pend && !exp_rv);
    ofs = addr - 32'h8000_0000;
    m_exit_valid  = exp_gnt && we && kind == 3'd3 && ofs == 32'h0;
    m_print_valid = exp_gnt && we && kind == 3'd3 && ofs == 32'h4;
    if (m_exit_valid) m_exit_code = wdata;
    if (m_print_valid) m_print_char = wdata[7:0];
    #1;
  endtask

  task automatic idle(input logic [2:0] rv);
    step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, rv);
  endtask

  task automatic do_reset();
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0; data_addr_i = 32'h0;
    data_wdata_i = 32'h0; tgt_gnt_i = '0; tgt_r_valid_i = '0; tgt_r_data_i = '0;
    rst_ni = 1'b0;
    exp_q.delete();
    viol_pend = 1'b0; m_exit_valid = 1'b0; m_print_valid = 1'b0;
    m_exit_code = 32'hFFFF_FFFF; m_print_char = 8'h0;
    @(negedge clk_i);
    check("rst_gnt", data_gnt_o, 1'b0);
    check("rst_rvalid", data_rvalid_o, 1'b0);
    check("rst_rdata", data_rdata_o, 32'h0);
    check("rst_err", data_err_o, 1'b0);
    check("rst_tgt_req", tgt_req_o, 3'b000);
    check("rst_tgt_add", tgt_add_o, 96'h0);
    check("rst_tgt_data", tgt_data_o, 96'h0);
    check("rst_exit_valid", exit_valid_o, 1'b0);
    check("rst_exit_code", exit_code_o, 32'hFFFF_FFFF);
    check("rst_print_valid", print_valid_o, 1'b0);
    check("rst_print_char", print_char_o, 8'h0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  initial begin
    logic [31:0] edges [6];
    logic [31:0] addr;
    int          sel;
    edges = '{32'h0000_0FFF, 32'h0010_0000, 32'h0017_0000, 32'h8000_0010, 32'h0013_FFFC, 32'h0011_0000};
    rst_ni = 1'b0;
    do_reset();

    // Single dmem load, then a late r_valid on an empty FIFO.
    step(1'b1, 1'b0, 32'h0011_0010, 32'h0, 3'b100, 3'b000);
    idle(3'b100);
    idle(3'b100);

    // Four loads fill the FIFO; the fifth waits for the first pop.
    step(1'b1, 1'b0, 32'h0014_0000, 32'h0, 3'b111, 3'b000);
    step(1'b1, 1'b0, 32'h0011_0010, 32'h0, 3'b111, 3'b000);
    step(1'b1, 1'b0, 32'h0014_0004, 32'h0, 3'b111, 3'b000);
    step(1'b1, 1'b0, 32'h0011_0014, 32'h0, 3'b111, 3'b000);
    step(1'b1, 1'b0, 32'h0014_0008, 32'h0, 3'b111, 3'b000);
    step(1'b1, 1'b0, 32'h0014_0008, 32'h0, 3'b111, 3'b010);
    step(1'b1, 1'b0, 32'h0014_0008, 32'h0, 3'b111, 3'b000);
    idle(3'b000);
    idle(3'b000);
    idle(3'b100);
    idle(3'b010);
    idle(3'b000);
    idle(3'b100);
    idle(3'b010);

    // PRINT then EXIT stores.
    step(1'b1, 1'b1, 32'h8000_0004, 32'h0000_0041, 3'b000, 3'b000);
    step(1'b1, 1'b1, 32'h8000_0000, 32'h0000_0000, 3'b000, 3'b000);
    idle(3'b000);
    idle(3'b000);

    // Unmapped load.
    step(1'b1, 1'b0, 32'h0030_0000, 32'h0, 3'b111, 3'b000);
    idle(3'b000);

    // Stack reply while a dmem load is at the head.
    step(1'b1, 1'b0, 32'h0011_0020, 32'h0, 3'b100, 3'b000);
    idle(3'b010);
    idle(3'b100);
    step(1'b1, 1'b0, 32'h8000_0008, 32'h0, 3'b000, 3'b000);
    idle(3'b000);

    // Reset with three loads outstanding, then a stray dmem reply.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0011_0100 + 32'(4 * i), 32'h0, 3'b100, 3'b000);
    do_reset();
    idle(3'b100);
    idle(3'b000);

    // Randomized traffic with well-behaved targets answering only at the head.
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0:       addr = $urandom_range(32'h0000_1000, 32'h000F_FFFF);
        1:       addr = $urandom_range(32'h0014_0000, 32'h0016_FFFF);
        2:       addr = $urandom_range(32'h0011_0000, 32'h0013_FFFF);
        3:       addr = 32'h8000_0000 + 32'(4 * $urandom_range(0, 3));
        4:       addr = $urandom_range(32'h0020_0000, 32'h7FFF_FFFF);
        default: addr = edges[$urandom_range(0, 5)];
      endcase
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), addr, $urandom,
           3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0) ? head_rv_onehot() : 3'b000);
    end
    for (int n = 0; n < 8; n++) idle(head_rv_onehot());
    idle(3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
